// File: rtl/antares_lsu_if.sv
// Data-port bus between the LSU (master) and the data memory/bus fabric (slave).
interface antares_lsu_if;
  logic [31:0] dport_address;
  logic [31:0] dport_data_o;
  logic [3:0]  dport_wr;
  logic        dport_enable;
  logic [31:0] dport_data_i;
  logic        dport_ready;
  logic        dport_error;

  modport master (
    output dport_address, dport_data_o, dport_wr, dport_enable,
    input  dport_data_i, dport_ready, dport_error
  );

  modport slave (
    input  dport_address, dport_data_o, dport_wr, dport_enable,
    output dport_data_i, dport_ready, dport_error
  );
endinterface

// File: rtl/antares_lsu.sv
// Single-outstanding big-endian load/store unit between the MEM stage and the data port.
// Optional bus timeout abort is enabled by defining ANTARES_LSU_TIMEOUT_EN.
module antares_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_store_data,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          mem_byte,
  input  logic          mem_halfword,
  input  logic          mem_sign_extend,
  input  logic          mem_stall,
  input  logic          mem_flush,
  output logic [31:0]   mem_read_data,
  output logic          mem_request_stall,
  output logic          exc_address_l_mem,
  output logic          exc_address_s_mem,
  output logic          exc_bus_error,
  antares_lsu_if.master dport
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;

  logic        misaligned, start, flush_now, timeout;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_val;
  logic [3:0]  wr_q, wr_d;
  logic [1:0]  lane_q, lane_d;
  logic        byte_q, byte_d, half_q, half_d, sext_q, sext_d, load_q, load_d;
  logic        flushed_q, flushed_d, berr_q, berr_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        unused_store_hi;

  assign misaligned = (mem_halfword & mem_address[0])
                    | (~mem_byte & ~mem_halfword & (mem_address[1:0] != 2'b00));
  assign exc_address_l_mem = mem_read & misaligned;
  assign exc_address_s_mem = mem_write & misaligned;
  assign start      = (state_q == IDLE) & (mem_read | mem_write) & ~misaligned & ~mem_flush;
  assign flush_now  = flushed_q | mem_flush;
  assign unused_store_hi = ^mem_store_data[31:16];

`ifdef ANTARES_LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the index of the current BUSY cycle; ready on the last one still wins.
  assign timeout = (state_q == BUSY) & ~dport.dport_ready
                 & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start)                 cnt_d = '0;
    else if (state_q == BUSY)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (dport.dport_ready || timeout) state_d = flush_now ? IDLE : DONE;
      DONE:    if (!mem_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_request_stall  = start | (state_q == BUSY);
    dport.dport_enable = (state_q == BUSY);
  end

  assign dport.dport_address = addr_q;
  assign dport.dport_data_o  = wdata_q;
  assign dport.dport_wr      = wr_q;
  assign mem_read_data       = rdata_q;
  assign exc_bus_error       = berr_q;

  always_comb begin
    unique case (lane_q)
      2'd0:    lane_b = dport.dport_data_i[31:24];
      2'd1:    lane_b = dport.dport_data_i[23:16];
      2'd2:    lane_b = dport.dport_data_i[15:8];
      default: lane_b = dport.dport_data_i[7:0];
    endcase
    lane_h = lane_q[1] ? dport.dport_data_i[15:0] : dport.dport_data_i[31:16];
    if (byte_q)      load_val = {{24{sext_q & lane_b[7]}}, lane_b};
    else if (half_q) load_val = {{16{sext_q & lane_h[15]}}, lane_h};
    else             load_val = dport.dport_data_i;
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    lane_d    = lane_q;
    byte_d    = byte_q;
    half_d    = half_q;
    sext_d    = sext_q;
    load_d    = load_q;
    flushed_d = flushed_q;
    rdata_d   = rdata_q;
    berr_d    = berr_q;
    if (start) begin
      addr_d    = {mem_address[31:2], 2'b00};
      lane_d    = mem_address[1:0];
      byte_d    = mem_byte;
      half_d    = mem_halfword;
      sext_d    = mem_sign_extend;
      load_d    = mem_read;
      flushed_d = 1'b0;
      if (mem_write) begin
        if (mem_byte) begin
          wr_d    = 4'b1000 >> mem_address[1:0];
          wdata_d = {4{mem_store_data[7:0]}};
        end else if (mem_halfword) begin
          wr_d    = mem_address[1] ? 4'b0011 : 4'b1100;
          wdata_d = {2{mem_store_data[15:0]}};
        end else begin
          wr_d    = '1;
          wdata_d = mem_store_data;
        end
      end else begin
        wr_d    = '0;
        wdata_d = '0;
      end
    end else if ((state_q == BUSY) && mem_flush) begin
      flushed_d = 1'b1;
    end
    // Entering DONE without a clean ready means bus error or timeout.
    if ((state_q == BUSY) && (state_d == DONE)) begin
      if (dport.dport_ready && !dport.dport_error) begin
        if (load_q) rdata_d = load_val;
      end else begin
        berr_d = 1'b1;
      end
    end
    if ((state_q == DONE) && (state_d == IDLE)) berr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= '0;
      lane_q    <= '0;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      sext_q    <= 1'b0;
      load_q    <= 1'b0;
      flushed_q <= 1'b0;
      rdata_q   <= '0;
      berr_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      lane_q    <= lane_d;
      byte_q    <= byte_d;
      half_q    <= half_d;
      sext_q    <= sext_d;
      load_q    <= load_d;
      flushed_q <= flushed_d;
      rdata_q   <= rdata_d;
      berr_q    <= berr_d;
    end
  end

endmodule

// File: doc/antares_lsu.md
ANTARES_LSU -- requirements
Module: antares_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus wait cycles before abort; used only with ANTARES_LSU_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  clock; every flop updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_address  input  32  byte address (EX ALU result, registered by EX/MEM).
REQ-005 SHALL have port mem_store_data  input  32  store data, right-justified.
REQ-006 SHALL have ports mem_read, mem_write  input  1 each  load request / store request.
REQ-007 SHALL have ports mem_byte, mem_halfword, mem_sign_extend  input  1 each  access size (neither = word) / load extension.
REQ-008 SHALL have ports mem_stall, mem_flush  input  1 each  pipeline stall / kill of MEM instruction.
REQ-009 SHALL have ports dport_address (32), dport_data_o (32), dport_wr (4), dport_enable (1)  output  bus request.
REQ-010 SHALL have ports dport_data_i (32), dport_ready (1), dport_error (1)  input  bus response.
REQ-011 SHALL have outputs mem_read_data (32), mem_request_stall (1), exc_address_l_mem (1), exc_address_s_mem (1), exc_bus_error (1).

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL define misaligned = (halfword & addr[0]) | (word & addr[1:0]!=0); exc_address_l_mem = read & misaligned, exc_address_s_mem = write & misaligned, combinational.
REQ-014 SHALL define start = IDLE & (read|write) & ~misaligned & ~mem_flush.
REQ-015 SHALL on start register address {addr[31:2],2'b00}, lane-aligned data, dport_wr, and enter BUSY; dport_enable = 1 exactly while BUSY.
REQ-016 SHALL be big-endian: addr[1:0]=0 selects bits 31:24; byte store wr = 4'b1000>>addr[1:0], data = {4{d[7:0]}}; halfword store wr = 1100 (addr[1]=0) or 0011, data = {2{d[15:0]}}; word wr = 1111; loads wr = 0000.
REQ-017 SHALL hold dport_* outputs stable throughout BUSY.
REQ-018 SHALL in BUSY with dport_ready=1 capture selected lane of dport_data_i, sign-extended if mem_sign_extend else zero-extended, into mem_read_data, and enter DONE (IDLE if flushed during BUSY).
REQ-019 SHALL assert mem_request_stall = start | BUSY; deasserted in DONE and in idle without start.
REQ-020 SHALL in DONE go to IDLE when mem_stall=0, else remain; no reissue of the same access.
REQ-021 SHALL give minimum 2 stall cycles (start cycle, one BUSY cycle with immediate ready).
REQ-022 SHALL, on mem_flush during BUSY, not abort the bus cycle, keep stalling, discard data, return to IDLE on ready.
REQ-023 SHALL on ready with dport_error=1 set exc_bus_error, held through DONE, cleared on leaving DONE; mem_read_data unchanged.
REQ-024 SHALL leave mem_read_data unchanged on stores and in IDLE.
REQ-025 SHALL issue no bus cycle for misaligned or flushed requests.

Reset
REQ-026 SHALL on rst force IDLE, dport_enable=0, dport_wr=0, dport_address=0, dport_data_o=0, mem_read_data=0, exc_bus_error=0, timeout counter=0, overriding any state including mid-BUSY.

Configuration
REQ-027 SHALL, with ANTARES_LSU_TIMEOUT_EN defined, count BUSY cycles from 0; if TIMEOUT_CYCLES elapse without dport_ready, drop dport_enable, set exc_bus_error, enter DONE; counter clears on entering BUSY.
REQ-028 SHALL, without ANTARES_LSU_TIMEOUT_EN, contain no counter and wait indefinitely in BUSY.

Verification
REQ-029 Byte load addr 0x103, sign_extend=1, bus returns 0x123456F0 after 3 cycles -> dport_wr=0000, mem_read_data=0xFFFFFFF0, 4 stall cycles.
REQ-030 Halfword store addr 0x202, data 0x0000ABCD, immediate ready -> dport_address=0x200, dport_wr=0011, dport_data_o=0xABCDABCD, stall 2 cycles.
REQ-031 Word load addr 0x106 -> exc_address_l_mem=1, dport_enable never asserted, no stall.
REQ-032 Load completes while mem_stall=1 for 5 cycles -> stays DONE, single bus cycle, mem_read_data stable.
REQ-033 mem_flush during BUSY, ready 2 cycles later -> no DONE, mem_read_data unchanged; rst mid-BUSY -> dport_enable=0 next cycle.
REQ-034 ANTARES_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ready -> dport_enable low after 4 BUSY cycles, exc_bus_error=1.
